strm_serializer: RTL and testbench
==================================

Name: strm_serializer

Overview:
- Width-down converter for the stream protocol. Accepts one wide word on a strm_intf sink port and emits it as RATIO narrow beats on a strm_intf source port.
- Sits on the consumer (read) side of a wide fifo. It feeds narrow links such as commctrl TX lanes and scan/debug outputs.
- Holds one word at a time; sustains one narrow beat per cycle, with back-to-back words and no bubble.

Parameters:
- IN_WIDTH, 64, data width of the input stream.
- OUT_WIDTH, 16, data width of the output stream. Must divide IN_WIDTH exactly.
- LSB_FIRST, 1, 1 = least-significant slice is sent first; 0 = most-significant slice is sent first.
- Derived: RATIO = IN_WIDTH/OUT_WIDTH. RATIO >= 2 is required; an elaboration-time check fails the build otherwise.

Ports:
- clk  input  1  single clock, rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- in  strm_intf.sink  IN_WIDTH  wide input stream (valid, ready, data).
- out  strm_intf.source  OUT_WIDTH  narrow output stream (valid, ready, data).
- busy  output  1  high while a word is held (state SEND).

Behaviour:
- Registers: hold_q[IN_WIDTH-1:0], beat_q[$clog2(RATIO)-1:0], state_q in {IDLE, SEND}.
- Reset (async, rstn low): state_q=IDLE, beat_q=0, hold_q=0, out.valid=0, in.ready=1, busy=0. The reset value of out.data is 0.
- Transfers: in_xfer = in.valid & in.ready; out_xfer = out.valid & out.ready.
- in.ready (combinational) = (state_q==IDLE) | (state_q==SEND & beat_q==RATIO-1 & out.ready).
- out.valid = (state_q==SEND), driven from a register. busy = out.valid.
- out.data = slice beat_q of hold_q (LSB_FIRST=1) or slice RATIO-1-beat_q (LSB_FIRST=0).
- IDLE: on in_xfer, load hold_q=in.data, beat_q=0, go to SEND.
- SEND, out_xfer with beat_q<RATIO-1: beat_q+1.
- SEND, out_xfer with beat_q==RATIO-1 (last beat):
  - if in.valid: reload hold_q, set beat_q=0, stay in SEND (zero-bubble).
  - else: set beat_q=0, go to IDLE.
- SEND without out_xfer: hold every register. out.data and out.valid stay stable while valid & !ready.
- Latency: word accepted at edge N; first beat valid after edge N.
- Throughput: RATIO cycles per word under continuous ready.
- Backpressure: out.ready low stalls indefinitely. in.ready stays low until the last beat is accepted.
- Boundaries:
  - beat_q wraps only through the last-beat rule and never exceeds RATIO-1.
  - An in.valid arriving mid-word is ignored (not consumed) until the last beat.
  - Reset mid-word discards the held word; no partial beats are emitted afterwards.
- No combinational path from in.valid/in.data to out.*. The only combinational path is out.ready -> in.ready.

Optional Feature:
- Macro: STRM_SERIALIZER_LAST_EN.
- Defined:
  - adds port out_last (output, 1): high exactly when out.valid & beat_q==RATIO-1, reset 0.
  - adds port in_first (output, 1): pulses high for the cycle of each in_xfer.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
- Single word, LSB_FIRST=1:
  - stimulus: in.data=0x4444_3333_2222_1111, out.ready=1.
  - response: beats 0x1111, 0x2222, 0x3333, 0x4444 on 4 consecutive cycles; then out.valid=0 and in.ready=1.
- Back-to-back: two words 0xA..., 0xB... presented with in.valid held high, out.ready=1 → 8 beats with no gap; the second in_xfer occurs in the same cycle as the first word's last beat.
- Stall: out.ready=0 for 5 cycles during beat 1 → out.data=0x2222 and valid are held for all 5 cycles; beat count is unchanged; in.ready=0 throughout.
- LSB_FIRST=0, same word → beats 0x4444, 0x3333, 0x2222, 0x1111.
- Reset mid-word: assert rstn=0 after beat 1, release 2 cycles later → out.valid=0 immediately (async), busy=0, in.ready=1, beat_q=0; the next word starts at slice 0.
- With STRM_SERIALIZER_LAST_EN: out_last high only on the 0x4444 beat; in_first high one cycle per word accepted.

Source files
------------

// File: rtl/strm_serializer.sv
// rtl/strm_serializer.sv - wide-to-narrow stream serializer
//
// Purpose: accepts one IN_WIDTH word and emits it as RATIO = IN_WIDTH/OUT_WIDTH
// narrow beats. Back-to-back words are sustained with no bubble. The next word
// is loaded in the same cycle that the last beat of the current word is taken.
//
// Optional feature macro: STRM_SERIALIZER_LAST_EN (adds out_last, in_first).
//
// Ports:
//   clk        clock, rising edge
//   rstn       asynchronous active-low reset
//   in_valid   wide input stream valid
//   in_ready   wide input stream ready (combinational from out_ready)
//   in_data    wide input stream data [IN_WIDTH-1:0]
//   out_valid  narrow output stream valid (registered state)
//   out_ready  narrow output stream ready
//   out_data   narrow output stream data [OUT_WIDTH-1:0]
//   busy       high while a word is held
//   out_last   (macro) high on the final beat of a word
//   in_first   (macro) high in each cycle that a word is accepted

module strm_serializer #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 16,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 busy
`ifdef STRM_SERIALIZER_LAST_EN
  ,
  output logic                 out_last,
  output logic                 in_first
`endif
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int BW    = (RATIO < 2) ? 1 : $clog2(RATIO);
  localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

  if (RATIO < 2 || RATIO * OUT_WIDTH != IN_WIDTH) begin : g_bad_ratio
    $error("strm_serializer: OUT_WIDTH must divide IN_WIDTH with a ratio of at least 2");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state_q;
  logic [BW-1:0]        beat_q;
  logic [IN_WIDTH-1:0]  hold_q;
  logic                 last_beat;
  logic [BW-1:0]        sel;

  assign last_beat = (beat_q == LAST_BEAT);

  // The only combinational path through the block: out_ready -> in_ready,
  // which lets a new word load on the cycle the last beat leaves.
  assign in_ready  = (state_q == IDLE) || (last_beat && out_ready);
  assign out_valid = (state_q == SEND);
  assign busy      = out_valid;

  assign sel = LSB_FIRST ? beat_q : (LAST_BEAT - beat_q);

  always_comb begin
    out_data = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (sel == BW'(i)) begin
        out_data = hold_q[i*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

`ifdef STRM_SERIALIZER_LAST_EN
  assign out_last = out_valid && last_beat;
  assign in_first = in_valid && in_ready;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      beat_q  <= '0;
      hold_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            hold_q  <= in_data;
            beat_q  <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (last_beat) begin
              beat_q <= '0;
              if (in_valid) begin
                hold_q <= in_data;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              beat_q <= beat_q + BW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_strm_serializer.sv
// tb/tb_strm_serializer.sv - self-checking bench for strm_serializer
//
// Two instances share the input stream: one sends the least-significant slice
// first, the other the most-significant slice first. A queue of expected beats
// per instance is the reference.

module tb_strm_serializer;

  localparam int IW = 64;
  localparam int OW = 16;
  localparam int R  = IW / OW;
`ifdef STRM_SERIALIZER_LAST_EN
  localparam int VW = 2 * (3 + OW) + 4;
`else
  localparam int VW = 2 * (3 + OW);
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_valid = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          out_ready = 1'b0;

  logic          in_ready_l, out_valid_l, busy_l;
  logic [OW-1:0] out_data_l;
  logic          in_ready_m, out_valid_m, busy_m;
  logic [OW-1:0] out_data_m;
`ifdef STRM_SERIALIZER_LAST_EN
  logic          out_last_l, in_first_l, out_last_m, in_first_m;
`endif

  always #5 clk = ~clk;

  strm_serializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready_l), .in_data(in_data),
    .out_valid(out_valid_l), .out_ready(out_ready), .out_data(out_data_l),
    .busy(busy_l)
`ifdef STRM_SERIALIZER_LAST_EN
    , .out_last(out_last_l), .in_first(in_first_l)
`endif
  );

  strm_serializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready_m), .in_data(in_data),
    .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m),
    .busy(busy_m)
`ifdef STRM_SERIALIZER_LAST_EN
    , .out_last(out_last_m), .in_first(in_first_m)
`endif
  );

  // Reference: pending narrow beats of the held word, in emission order.
  logic [OW-1:0] q_l[$];
  logic [OW-1:0] q_m[$];

  int tests_run = 0;
  int tests_failed = 0;

  logic [VW-1:0] s_obs, s_exp;
  logic [OW-1:0] s_data_l, s_data_m;
  logic          s_valid_l, s_ready_l;

  function automatic logic [VW-1:0] obs_vec();
    logic [OW-1:0] dl, dm;
    dl = (q_l.size() != 0) ? out_data_l : '0;
    dm = (q_m.size() != 0) ? out_data_m : '0;
`ifdef STRM_SERIALIZER_LAST_EN
    return {out_valid_l, in_ready_l, busy_l, dl, out_valid_m, in_ready_m, busy_m, dm,
            out_last_l, in_first_l, out_last_m, in_first_m};
`else
    return {out_valid_l, in_ready_l, busy_l, dl, out_valid_m, in_ready_m, busy_m, dm};
`endif
  endfunction

  function automatic logic exp_ready();
    return (q_l.size() == 0) || (q_l.size() == 1 && out_ready);
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic          v, rd;
    logic [OW-1:0] dl, dm;
    v  = (q_l.size() != 0);
    rd = exp_ready();
    dl = v ? q_l[0] : '0;
    dm = v ? q_m[0] : '0;
`ifdef STRM_SERIALIZER_LAST_EN
    return {v, rd, v, dl, v, rd, v, dm,
            q_l.size() == 1, in_valid && rd, q_l.size() == 1, in_valid && rd};
`else
    return {v, rd, v, dl, v, rd, v, dm};
`endif
  endfunction

  // One clock: drive at the falling edge, sample 1ns later, advance the
  // reference on the rising edge.
  task automatic tick(input logic v, input logic [IW-1:0] d, input logic r);
    logic acc, pop;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    s_obs     = obs_vec();
    s_exp     = exp_vec();
    s_data_l  = out_data_l;
    s_data_m  = out_data_m;
    s_valid_l = out_valid_l;
    s_ready_l = in_ready_l;
    acc = v && exp_ready();
    pop = (q_l.size() != 0) && r;
    @(posedge clk);
    if (pop) begin
      void'(q_l.pop_front());
      void'(q_m.pop_front());
    end
    if (acc) begin
      for (int k = 0; k < R; k++) begin
        q_l.push_back(d[k*OW +: OW]);
        q_m.push_back(d[(R-1-k)*OW +: OW]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    tests_run++;
    if ({out_valid_l, busy_l, in_ready_l, out_data_l, out_valid_m, busy_m, in_ready_m, out_data_m}
        !== {1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0}) begin
      tests_failed++;
      $display("FAIL reset: got v=%b b=%b r=%b d=%h / v=%b b=%b r=%b d=%h want v=0 b=0 r=1 d=0",
               out_valid_l, busy_l, in_ready_l, out_data_l, out_valid_m, busy_m, in_ready_m, out_data_m);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_single_word();
    logic [OW-1:0] want_l[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int c = 0; c < 6; c++) begin
      tick(c == 0, 64'h4444_3333_2222_1111, 1'b1);
      tests_run++;
      if (s_obs !== s_exp) begin
        tests_failed++;
        $display("FAIL single_word cycle %0d: got %h want %h", c, s_obs, s_exp);
      end
      if (c >= 1 && c <= 4) begin
        tests_run++;
        if ({s_valid_l, s_data_l, s_data_m} !== {1'b1, want_l[c-1], want_l[4-c]}) begin
          tests_failed++;
          $display("FAIL single_word_beat %0d: got v=%b %h/%h want v=1 %h/%h",
                   c - 1, s_valid_l, s_data_l, s_data_m, want_l[c-1], want_l[4-c]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int valid_cycles = 0;
    for (int c = 0; c < 10; c++) begin
      // A is offered once; B is held valid until it is taken on A's last beat.
      tick(c <= 4, (c == 0) ? 64'hA004_A003_A002_A001 : 64'hB004_B003_B002_B001, 1'b1);
      if (s_valid_l) valid_cycles++;
      tests_run++;
      if (s_obs !== s_exp) begin
        tests_failed++;
        $display("FAIL back_to_back cycle %0d: got %h want %h", c, s_obs, s_exp);
      end
      if (c == 4) begin
        tests_run++;
        if ({s_ready_l, s_data_l} !== {1'b1, 16'hA004}) begin
          tests_failed++;
          $display("FAIL b2b_reload: got ready=%b data=%h want ready=1 data=a004", s_ready_l, s_data_l);
        end
      end
    end
    tests_run++;
    if (valid_cycles != 8) begin
      tests_failed++;
      $display("FAIL b2b_gapless: got %0d valid cycles want 8", valid_cycles);
    end
  endtask

  task automatic test_stall();
    int guard;
    tick(1'b1, 64'h4444_3333_2222_1111, 1'b1);
    tick(1'b0, '0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick(1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0);
      tests_run++;
      if ({s_valid_l, s_ready_l, s_data_l} !== {1'b1, 1'b0, 16'h2222} || s_obs !== s_exp) begin
        tests_failed++;
        $display("FAIL stall cycle %0d: got v=%b r=%b d=%h (%h) want v=1 r=0 d=2222 (%h)",
                 c, s_valid_l, s_ready_l, s_data_l, s_obs, s_exp);
      end
    end
    guard = 0;
    while (q_l.size() != 0 && guard < 20) begin
      tick(1'b0, '0, 1'b1);
      guard++;
      tests_run++;
      if (s_obs !== s_exp) begin
        tests_failed++;
        $display("FAIL stall_drain cycle %0d: got %h want %h", guard, s_obs, s_exp);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    tick(1'b1, 64'h8888_7777_6666_5555, 1'b1);
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    tests_run++;
    if ({out_valid_l, busy_l, in_ready_l, out_valid_m, busy_m, in_ready_m} !== 6'b001_001) begin
      tests_failed++;
      $display("FAIL reset_mid_word: got v=%b b=%b r=%b / v=%b b=%b r=%b want v=0 b=0 r=1",
               out_valid_l, busy_l, in_ready_l, out_valid_m, busy_m, in_ready_m);
    end
    q_l.delete();
    q_m.delete();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick(c == 0, 64'hDDDD_CCCC_BBBB_AAAA, 1'b1);
      tests_run++;
      if (s_obs !== s_exp) begin
        tests_failed++;
        $display("FAIL post_reset cycle %0d: got %h want %h", c, s_obs, s_exp);
      end
      if (c == 1) begin
        tests_run++;
        if ({s_data_l, s_data_m} !== {16'hAAAA, 16'hDDDD}) begin
          tests_failed++;
          $display("FAIL post_reset_first: got %h/%h want aaaa/dddd", s_data_l, s_data_m);
        end
      end
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 400; c++) begin
      tick($urandom_range(0, 99) < 60, {$urandom(), $urandom()}, $urandom_range(0, 99) < 70);
      tests_run++;
      if (s_obs !== s_exp) begin
        tests_failed++;
        errs++;
        if (errs <= 10) $display("FAIL random cycle %0d: got %h want %h", c, s_obs, s_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_reset_mid_word();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
